// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array: sum width derivation, column slice
// position helper and the drop counter width used by the PE, feeder and drain.
package sa_pkg;

    localparam int DROP_CNT_W = 8;

    function automatic int sum_width(input int data_width);
        return data_width * data_width;
    endfunction

    function automatic int col_lsb(input int col, input int sum_w);
        return col * sum_w;
    endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// Synchronous row FIFO with a registered head entry; the head register always
// holds the entry that will be at the front in the next cycle.
module sa_row_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    assign o_full       = (r_count == CNT_W'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_head       = r_head;
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(i_pop);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The pushed entry bypasses memory when it is the one that becomes head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
        end else if (i_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            r_head <= i_data;
        end else begin
            r_head <= r_mem[w_rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/sa_output_drain.sv
// De-skews staggered column sums from the bottom PE row into aligned rows,
// buffers them and tracks rows lost to back-pressure.
module sa_output_drain
    import sa_pkg::*;
#(
    parameter  int DATA_WIDTH = 4,
    parameter  int COLS       = 4,
    parameter  int DEPTH      = 4,
    localparam int SUM_W      = sum_width(DATA_WIDTH),
    localparam int ROW_W      = COLS * SUM_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [ROW_W-1:0]      col_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROW_W-1:0]      out_row,
    output logic                  overflow,
    input  logic                  clear_ovf,
    output logic [DROP_CNT_W-1:0] drop_count
);

    logic [ROW_W-1:0]      w_row_aligned;
    logic                  w_aligned_vld;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_count;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

    // De-skew triangle: column j waits COLS-1-j cycles for the rightmost column.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int D   = COLS - 1 - j;
        localparam int LSB = col_lsb(j, SUM_W);
        if (D == 0) begin : g_pass
            assign w_row_aligned[LSB +: SUM_W] = col_sum[LSB +: SUM_W];
        end else begin : g_dly
            logic [SUM_W-1:0] r_dly [D];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < D; k++) r_dly[k] <= '0;
                end else begin
                    r_dly[0] <= col_sum[LSB +: SUM_W];
                    for (int k = 1; k < D; k++) r_dly[k] <= r_dly[k-1];
                end
            end
            assign w_row_aligned[LSB +: SUM_W] = r_dly[D-1];
        end
    end

    if (COLS > 1) begin : g_vld
        logic r_vld [COLS-1];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < COLS - 1; k++) r_vld[k] <= 1'b0;
            end else begin
                r_vld[0] <= in_valid;
                for (int k = 1; k < COLS - 1; k++) r_vld[k] <= r_vld[k-1];
            end
        end
        assign w_aligned_vld = r_vld[COLS-2];
    end else begin : g_novld
        assign w_aligned_vld = in_valid;
    end

    // Buffering: a full FIFO still accepts a row when the head leaves the same cycle.
    assign w_pop  = ~w_empty & out_ready;
    assign w_push = w_aligned_vld & (~w_full | w_pop);
    assign w_drop = w_aligned_vld & w_full & ~w_pop;

    sa_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_row_aligned),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (out_row)
    );

    assign out_valid = ~w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow   <= 1'b1;
            r_drop_count <= clear_ovf ? DROP_CNT_W'(1) : sat_inc(r_drop_count);
        end else if (clear_ovf) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: doc/sa_output_drain.md
# sa_output_drain

Output drain for the weight-stationary systolic array. Each column's bottom processing element emits its accumulated sum one cycle later than the column to its left. This block de-skews those staggered column sums into one aligned result row and buffers rows in a small FIFO. It presents them downstream on a valid/ready handshake, and it flags and counts rows lost to back-pressure. It sits between the last PE row of the array and the result consumer (memory writer or host interface).

## Interface
Parameters:
- DATA_WIDTH, 4, operand width used by the PEs; sum width SUM_W = DATA_WIDTH*DATA_WIDTH
- COLS, 4, number of array columns (>= 1)
- DEPTH, 4, result FIFO depth in rows (power of two, >= 2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clock clk
- in_valid  input  1  column-0 sum valid this cycle; column j's sum of the same row is valid j cycles later
- col_sum  input  COLS*SUM_W  signed column sums; column j at bits [j*SUM_W +: SUM_W]
- out_valid  output  1  FIFO head row valid
- out_ready  input  1  consumer accepts head row when out_valid && out_ready
- out_row  output  COLS*SUM_W  aligned result row, same packing as col_sum
- overflow  output  1  sticky: a row was dropped because the FIFO was full
- clear_ovf  input  1  synchronous clear of overflow and drop_count
- drop_count  output  8  saturating count of dropped rows

## Operation
- De-skew: column j passes through COLS-1-j registers, so column COLS-1 has 0 registers. in_valid passes through COLS-1 registers; its output is the aligned push strobe. Sums are captured verbatim, with no arithmetic or sign change.
- Delay registers load every cycle regardless of valid, so consecutive rows (in_valid high on back-to-back cycles) de-skew without bubbles.
- Push: the aligned strobe writes the aligned row into the FIFO.
- Push while full and no pop that cycle: the row is dropped, overflow is set, and drop_count increments, saturating at 255.
- Push while full with a pop in the same cycle: the push is accepted and the count is unchanged.
- Pop: out_valid && out_ready removes the head. With simultaneous push and pop on a non-empty FIFO, the count is unchanged.
- Push into an empty FIFO with a pop in the same cycle cannot occur, because out_valid is low.
- FIFO pointers wrap modulo DEPTH. Count runs 0..DEPTH. full = (count==DEPTH); empty = (count==0).
- clear_ovf clears overflow and drop_count. When it coincides with a drop, the drop wins: overflow becomes 1 and drop_count becomes 1.
- out_row shows the head entry whenever out_valid=1. It is don't-care when out_valid=0; the bench must not check it then.

## Timing
- Reset values: out_valid=0, overflow=0, drop_count=0, out_row=0. All delay registers, the valid pipeline and the FIFO pointers and count are cleared.
- Reset mid-operation discards in-flight rows and buffered rows; nothing is emitted after reset deasserts until a new in_valid.
- Latency: if in_valid is high in cycle t (column j valid in cycle t+j), the aligned push occurs at the edge ending cycle t+COLS-1. With an empty FIFO, out_valid rises in cycle t+COLS.
- Throughput: one row per cycle in and out; no combinational path from out_ready to out_valid.
- out_valid stays high and out_row stays stable until accepted.

## Structure
- Shared package/header sa_pkg: SUM_W derivation, a column-slice helper macro/function, and the drop_count width (8) constant; the PE and the feeder use the same items.
- One sub-module: sa_row_fifo, a synchronous FIFO of width COLS*SUM_W and depth DEPTH with push, pop, full, empty and a registered head.
- The de-skew triangle is generated inline in sa_output_drain.

## Test plan
All scenarios use COLS=4, DATA_WIDTH=4 (SUM_W=16), DEPTH=4.
- Single row: in_valid pulse at cycle 10, col j presents 0x0010+j at cycle 10+j → out_valid rises at cycle 14 with out_row = {0x0013,0x0012,0x0011,0x0010}, out_ready=1 → out_valid falls at cycle 15.
- Back-to-back: 8 consecutive rows, row r column j = r*16+j, out_ready=1 → 8 consecutive output rows in order with matching values, no gaps.
- Back-pressure: out_ready=0, push 6 rows → first 4 held, overflow=1, drop_count=2. Then out_ready=1 → rows 0..3 emerge, clear_ovf → overflow=0, drop_count=0.
- Full with simultaneous pop: FIFO full and out_ready=1 in the cycle a 5th row aligns → row accepted, drop_count stays 0, 5 rows emitted in order.
- Negative values: col sums 0xFFF8 (-8) in all columns → output bits identical, no sign corruption.
- Reset mid-flight: assert reset 2 cycles after in_valid, with 2 rows buffered → out_valid=0 immediately, and no output appears after release without new input.
